// File: rtl/floppy_track_stream.sv
// Streams one disk byte per BYTE_TICKS cep ticks from the shared track buffer,
// following head track/side and modelling the rotating byte position.
module floppy_track_stream #(
  parameter int BYTE_TICKS   = 128,
  parameter int SECTOR_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cep,
  input  logic        enable,
  input  logic [6:0]  track,
  input  logic        side,
  input  logic [15:0] trackBufferOffset,
  output logic [15:0] trackBufferAddr,
  input  logic [7:0]  trackBufferData,
  output logic [7:0]  readData,
  output logic        newByteReady,
  output logic        index
);
  localparam int            TW          = (BYTE_TICKS > 1) ? $clog2(BYTE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX    = TW'(BYTE_TICKS - 1);
  localparam logic [15:0]   SIDE_STRIDE = 16'(12 * SECTOR_BYTES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} fetchState_t;
  fetchState_t state, stateNext;

  logic [15:0]   pos, posNext, trackLen;
  logic [3:0]    sectors;
  logic [TW-1:0] timer, timerNext, timerBase;
  logic [6:0]    trackQ;
  logic          sideQ, enableQ;
  logic          headChange, fetchReq, loadByte;

  // Outer tracks carry more sectors (zoned recording).
  always_comb begin
    sectors = 4'd8;
    if      (track_lt(trackQ, 7'd16)) sectors = 4'd12;
    else if (track_lt(trackQ, 7'd32)) sectors = 4'd11;
    else if (track_lt(trackQ, 7'd48)) sectors = 4'd10;
    else if (track_lt(trackQ, 7'd64)) sectors = 4'd9;
    trackLen = 16'(sectors * SECTOR_BYTES);
  end

  function automatic logic track_lt(input logic [6:0] a, input logic [6:0] b);
    return a < b;
  endfunction

  always_comb begin
    headChange = (track != trackQ) || (side != sideQ);
    timerBase  = (enable && !enableQ) ? '0 : timer;
    timerNext  = timer;
    fetchReq   = 1'b0;
    if (headChange) begin
      timerNext = '0;
    end else if (enable) begin
      timerNext = timerBase;
      if (cep) begin
        if (timerBase == TICK_MAX) begin
          timerNext = '0;
          fetchReq  = 1'b1;
        end else begin
          timerNext = timerBase + TW'(1);
        end
      end
    end
  end

  // Fetch FSM: ADDR covers the one-clk buffer read latency.
  always_comb begin
    stateNext = state;
    loadByte  = 1'b0;
    case (state)
      IDLE: if (fetchReq) stateNext = ADDR;
      ADDR: stateNext = DATA;
      DATA: begin
        stateNext = IDLE;
        loadByte  = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    if (headChange) begin
      stateNext = IDLE;
      loadByte  = 1'b0;
    end
  end

  always_comb begin
    posNext = pos;
    if (headChange || pos >= trackLen) posNext = '0;
    else if (loadByte) posNext = (pos == trackLen - 16'd1) ? 16'd0 : pos + 16'd1;
  end

  // Head/enable copies load during reset so release sees no spurious change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pos             <= '0;
      timer           <= '0;
      readData        <= 8'h00;
      newByteReady    <= 1'b0;
      trackBufferAddr <= '0;
      trackQ          <= track;
      sideQ           <= side;
      enableQ         <= enable;
    end else begin
      state           <= stateNext;
      pos             <= posNext;
      timer           <= timerNext;
      newByteReady    <= loadByte;
      trackQ          <= track;
      sideQ           <= side;
      enableQ         <= enable;
      trackBufferAddr <= trackBufferOffset + (sideQ ? SIDE_STRIDE : 16'd0) + pos;
      if (loadByte) readData <= trackBufferData;
    end
  end

  assign index = (pos == 16'd0);

endmodule

// File: tb/tb_floppy_track_stream.sv
// Directed bench: main instance at default timing, fast instance for the track wrap.
module tb_floppy_track_stream;
  logic        clk = 1'b0;
  logic        rst, cep, en, sd;
  logic [6:0]  trk;
  logic [15:0] off, addr;
  logic [7:0]  ramData, rd;
  logic        nbr, idx;

  logic        fRst, fNbr, fIdx;
  logic [15:0] fAddr;
  logic [7:0]  fRam, fRd;
  logic        fCep = 1'b1, fEn = 1'b1, fSd = 1'b0;
  logic [6:0]  fTrk = 7'd70;
  logic [15:0] fOff = 16'd0;

  int checks = 0, errors = 0, cyc = 0, r = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ramData <= addr[7:0];
  always @(posedge clk) fRam <= fAddr[7:0];

  floppy_track_stream dut (
    .clk(clk), .reset(rst), .cep(cep), .enable(en), .track(trk), .side(sd),
    .trackBufferOffset(off), .trackBufferAddr(addr), .trackBufferData(ramData),
    .readData(rd), .newByteReady(nbr), .index(idx)
  );

  floppy_track_stream #(.BYTE_TICKS(3), .SECTOR_BYTES(1024)) fast (
    .clk(clk), .reset(fRst), .cep(fCep), .enable(fEn), .track(fTrk), .side(fSd),
    .trackBufferOffset(fOff), .trackBufferAddr(fAddr), .trackBufferData(fRam),
    .readData(fRd), .newByteReady(fNbr), .index(fIdx)
  );

  typedef struct {
    logic [6:0]  trk;
    logic        sd;
    logic [15:0] off;
    logic [15:0] expAddr;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic waitByte(input int limit, output logic got);
    int n = 0;
    got = 1'b0;
    while (n < limit && !got) begin
      tick();
      n++;
      got = nbr;
    end
  endtask

  task automatic doReset(input logic [6:0] t, input logic s, input logic [15:0] o);
    rst = 1'b1; trk = t; sd = s; off = o; en = 1'b1; cep = 1'b1;
    tick(); tick();
    rst = 1'b0;
    r = cyc;
  endtask

  initial begin
    logic got;
    int seen, c0, fCount, n;
    vecs[0] = '{7'd0,   1'b0, 16'd0,     16'd0};
    vecs[1] = '{7'd20,  1'b1, 16'd24576, 16'd36864};
    vecs[2] = '{7'd79,  1'b1, 16'd0,     16'd12288};
    vecs[3] = '{7'd5,   1'b0, 16'd24576, 16'd24576};
    vecs[4] = '{7'd100, 1'b1, 16'd60000, 16'd6752};

    rst = 1'b1; fRst = 1'b1; cep = 1'b1; en = 1'b1; trk = 7'd0; sd = 1'b0; off = 16'd0;
    repeat (3) tick();
    chk("rst_addr", addr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_nbr", nbr, 0);
    chk("rst_idx", idx, 1);

    // First byte latency and steady cadence
    rst = 1'b0; r = cyc;
    waitByte(300, got);
    chk("first_seen", got, 1);
    chk("first_time", cyc - r, 130);
    chk("first_rd", rd, 8'h00);
    chk("first_idx", idx, 0);
    tick();
    chk("pulse_width", nbr, 0);
    waitByte(300, got);
    chk("second_time", cyc - r, 258);
    chk("second_rd", rd, 8'h01);
    waitByte(300, got);
    chk("third_time", cyc - r, 386);
    chk("third_rd", rd, 8'h02);

    // Base address per track/side/offset
    for (int i = 0; i < 5; i++) begin
      doReset(vecs[i].trk, vecs[i].sd, vecs[i].off);
      tick(); tick();
      chk($sformatf("vec%0d_addr", i), addr, vecs[i].expAddr);
      chk($sformatf("vec%0d_idx", i), idx, 1);
    end

    // Track change while the third fetch is in ADDR
    doReset(7'd0, 1'b0, 16'h0010);
    waitByte(300, got);
    chk("abort_b0", rd, 8'h10);
    waitByte(300, got);
    chk("abort_b1", rd, 8'h11);
    repeat (126) tick();
    trk = 7'd1;
    tick(); tick();
    chk("abort_nbr", nbr, 0);
    chk("abort_rd", rd, 8'h11);
    chk("abort_idx", idx, 1);
    waitByte(300, got);
    chk("abort_next_time", cyc - r, 515);
    chk("abort_next_rd", rd, 8'h10);

    // Enable dropped for 1000 clks at pos 37
    doReset(7'd0, 1'b0, 16'd0);
    for (int i = 0; i < 37; i++) waitByte(300, got);
    chk("en_pos37_time", cyc - r, 4738);
    chk("en_pos37_rd", rd, 8'h24);
    en = 1'b0;
    seen = 0;
    repeat (1000) begin
      tick();
      if (nbr) seen++;
    end
    chk("en_low_pulses", seen, 0);
    chk("en_low_rd", rd, 8'h24);
    en = 1'b1; c0 = cyc;
    waitByte(300, got);
    chk("en_resume_time", cyc - c0, 130);
    chk("en_resume_rd", rd, 8'h25);

    // Reset during DATA
    doReset(7'd0, 1'b0, 16'h005A);
    waitByte(300, got);
    chk("rstdata_b0", rd, 8'h5A);
    repeat (127) tick();
    rst = 1'b1;
    #1;
    chk("rstdata_rd", rd, 8'h00);
    chk("rstdata_nbr", nbr, 0);
    chk("rstdata_addr", addr, 0);
    tick(); tick();
    rst = 1'b0; r = cyc;
    tick();
    chk("rstdata_idx", idx, 1);
    chk("rstdata_addr2", addr, 16'h005A);
    waitByte(300, got);
    chk("rstdata_next_time", cyc - r, 130);
    chk("rstdata_next_rd", rd, 8'h5A);

    // Wrap at trackLen 8192 on the fast instance
    fRst = 1'b0;
    fCount = 0; n = 0;
    while (fCount < 8191 && n < 30000) begin
      tick();
      n++;
      if (fNbr) fCount++;
    end
    chk("wrap_count", fCount, 8191);
    tick();
    chk("wrap_addr_last", fAddr, 16'd8191);
    chk("wrap_idx_last", fIdx, 0);
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      tick();
      n++;
      got = fNbr;
    end
    chk("wrap_seen", got, 1);
    chk("wrap_rd", fRd, 8'hFF);
    chk("wrap_idx0", fIdx, 1);
    tick();
    chk("wrap_addr0", fAddr, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/floppy_track_stream.md
FLOPPY_TRACK_STREAM -- requirements
Module: floppy_track_stream

Interface
REQ-001 Parameter BYTE_TICKS, default 128, meaning cep ticks per disk byte (8 bit cells x 2 us at 8 MHz cep).
REQ-002 Parameter SECTOR_BYTES, default 1024, meaning track-buffer bytes reserved per sector.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cep  input  1  one-clk timing enable; the byte timer advances only when high.
REQ-006 enable  input  1  drive motor on and drive selected; low freezes streaming.
REQ-007 track  input  7  current head track, 0..79.
REQ-008 side  input  1  head select, 0 = lower, 1 = upper.
REQ-009 trackBufferOffset  input  16  drive base address in the shared track buffer (0 internal, 24576 external).
REQ-010 trackBufferAddr  output  16  track-buffer read address.
REQ-011 trackBufferData  input  8  track-buffer read data, valid on the clk after trackBufferAddr is presented.
REQ-012 readData  output  8  last fetched disk byte.
REQ-013 newByteReady  output  1  one-clk pulse when readData has just been updated.
REQ-014 index  output  1  high while the byte position is 0.

Function
REQ-015 Sector count per track: 12 for tracks 0-15, 11 for 16-31, 10 for 32-47, 9 for 48-63, 8 for 64-79, and 8 for any track >= 80.
REQ-016 trackLen = sectors x SECTOR_BYTES, computed in at least 16 bits; with the defaults it ranges from 8192 to 12288.
REQ-017 Byte position pos (16 bit) counts 0..trackLen-1 and then wraps to 0.
REQ-018 trackBufferAddr = trackBufferOffset + side x (12 x SECTOR_BYTES) + pos, modulo 2^16, registered.
REQ-019 Byte timer counts cep ticks 0..BYTE_TICKS-1; when cep is high at count BYTE_TICKS-1, the timer wraps to 0 and requests a fetch.
REQ-020 Fetch FSM states: IDLE, ADDR, DATA.
REQ-021 IDLE -> ADDR on a fetch request; in ADDR, trackBufferAddr holds the address for the current pos.
REQ-022 ADDR -> DATA unconditionally after one clk, matching the one-clk read latency.
REQ-023 In DATA: latch trackBufferData into readData, pulse newByteReady for exactly this clk, advance pos with wrap, then return to IDLE.
REQ-024 A fetch takes 3 clks; fetch requests arriving while the FSM is not in IDLE are dropped (no queueing), since BYTE_TICKS >= 3 cep ticks.
REQ-025 enable low: the timer holds, the FSM completes any fetch in flight and then stays in IDLE, pos holds, and newByteReady stays 0 after the in-flight pulse.
REQ-026 enable rising: the timer restarts from 0; pos is unchanged.
REQ-027 A change of track or side (compared with a registered copy) sets pos to 0 and the timer to 0 on the next clk.
REQ-028 A track or side change during ADDR or DATA aborts that fetch: no newByteReady pulse and readData unchanged; the FSM goes to IDLE.
REQ-029 If a change of trackLen makes pos >= trackLen, pos is forced to 0; a track change covers this case through REQ-027.
REQ-030 index = (pos == 0), combinational from registered pos.
REQ-031 readData holds its value between fetches and is never cleared except by reset.

Reset
REQ-032 While reset is high: pos = 0, timer = 0, FSM = IDLE, readData = 8'h00, newByteReady = 0, trackBufferAddr = 0.
REQ-033 The registered track and side copies are loaded from the inputs during reset, so no spurious change is detected on release.
REQ-034 Reset asserted mid-fetch aborts the fetch immediately; first activity after release is the first fetch request.

Verification
REQ-035 Bench setup: cep=1 every clk, enable=1, track=0, side=0, offset=0, RAM returning addr[7:0] -> first newByteReady at clk 130 after reset release with readData=8'h00, then every 128 clks with readData 01, 02, ...
REQ-036 Wrap: track=70 (8 sectors), pos preloaded by running 8191 bytes -> the next fetch address is 8191, followed by address 0 with index=1.
REQ-037 Side/offset: offset=24576, side=1, track=20 -> first address is 24576+12288 = 36864.
REQ-038 Track change asserted during the ADDR state -> no newByteReady for that fetch; the next fetch 128 ticks later reads pos 0.
REQ-039 enable dropped for 1000 clks mid-track at pos=37 -> no pulses while low; after re-enable, the first fetch reads pos 37 at 130 clks.
REQ-040 Reset pulse during the DATA state with readData=8'h5A -> readData=8'h00 and newByteReady=0 immediately; pos=0 after release.
